// File: rtl/param_sort_engine.sv
// Parametrised odd-even transposition sorter with early exit on a swap-free pass.
// DOUT is the working array; DONE marks it as a finished result.
module param_sort_engine #(
  parameter  int N  = 4,
  parameter  int W  = 4,
  localparam int PW = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            desc,
  input  logic [N*W-1:0]  din,
  output logic [N*W-1:0]  dout,
  output logic            busy,
  output logic            done,
  output logic [PW-1:0]   passes
);

  typedef enum logic [1:0] {
    IDLE,
    EVEN,
    ODD,
    FINISH
  } state_t;

  localparam logic [PW-1:0] HALF = PW'((N + 1) / 2);

  state_t         state, state_n;
  logic [N*W-1:0] arr, arr_n;
  logic [N*W-1:0] even_arr, odd_arr;
  logic           mode, mode_n;
  logic           swp, swp_n;
  logic           even_sw, odd_sw;
  logic [PW-1:0]  cnt, cnt_n, cnt_inc;

  function automatic logic out_of_order(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         d
  );
    return d ? (a < b) : (a > b);
  endfunction

  // Unpaired edge elements simply keep their value from arr.
  always_comb begin
    even_arr = arr;
    even_sw  = 1'b0;
    for (int i = 0; i + 1 < N; i += 2) begin
      if (out_of_order(arr[i*W +: W], arr[(i+1)*W +: W], mode)) begin
        even_arr[i*W +: W]     = arr[(i+1)*W +: W];
        even_arr[(i+1)*W +: W] = arr[i*W +: W];
        even_sw                = 1'b1;
      end
    end
  end

  always_comb begin
    odd_arr = arr;
    odd_sw  = 1'b0;
    for (int i = 1; i + 1 < N; i += 2) begin
      if (out_of_order(arr[i*W +: W], arr[(i+1)*W +: W], mode)) begin
        odd_arr[i*W +: W]     = arr[(i+1)*W +: W];
        odd_arr[(i+1)*W +: W] = arr[i*W +: W];
        odd_sw                = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    arr_n   = arr;
    mode_n  = mode;
    swp_n   = swp;
    cnt_n   = cnt;
    cnt_inc = cnt + PW'(1);
    unique case (state)
      IDLE, FINISH: begin
        if (start) begin
          arr_n   = din;
          mode_n  = desc;
          cnt_n   = '0;
          swp_n   = 1'b0;
          state_n = EVEN;
        end
      end
      EVEN: begin
        arr_n   = even_arr;
        swp_n   = swp | even_sw;
        state_n = ODD;
      end
      ODD: begin
        arr_n = odd_arr;
        cnt_n = cnt_inc;
        // ceil(N/2) passes always suffice, so stop there too.
        if (!(swp || odd_sw) || cnt_inc == HALF) begin
          swp_n   = swp | odd_sw;
          state_n = FINISH;
        end else begin
          swp_n   = 1'b0;
          state_n = EVEN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      arr   <= '0;
      mode  <= 1'b0;
      swp   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      arr   <= arr_n;
      mode  <= mode_n;
      swp   <= swp_n;
      cnt   <= cnt_n;
    end
  end

  assign dout   = arr;
  assign passes = cnt;
  assign busy   = (state == EVEN) || (state == ODD);
  assign done   = (state == FINISH);

endmodule

// File: tb/tb_param_sort_engine.sv
// Scoreboard bench: N=4/W=4 directed vectors and N=7/W=8 random vectors.
// A negedge monitor per instance pops expectations when DONE rises.
module tb_param_sort_engine;

  typedef struct {
    logic [55:0] dout;
    int          passes;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0, desc4 = 1'b0;
  logic [15:0] din4 = '0, dout4;
  logic        busy4, done4;
  logic [2:0]  passes4;
  logic        start7 = 1'b0, desc7 = 1'b0;
  logic [55:0] din7 = '0, dout7;
  logic        busy7, done7;
  logic [3:0]  passes7;

  int   total = 0, bad = 0;
  exp_t q4[$], q7[$];
  exp_t e4, e7;
  int   lat4 = 0, lat7 = 0;
  logic pb4 = 0, pd4 = 0, pb7 = 0, pd7 = 0;

  param_sort_engine #(.N(4), .W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .desc(desc4),
    .din(din4), .dout(dout4), .busy(busy4), .done(done4),
    .passes(passes4)
  );

  param_sort_engine #(.N(7), .W(8)) u7 (
    .clk(clk), .rst_n(rst_n), .start(start7), .desc(desc7),
    .din(din7), .dout(dout7), .busy(busy7), .done(done7),
    .passes(passes7)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got none want event", nm);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      lat4 = 0; pb4 = 0; pd4 = 0;
    end else begin
      if (busy4) lat4 = pb4 ? lat4 + 1 : 1;
      if (done4 && !pd4) begin
        if (q4.size() == 0) begin
          miss("exp4");
        end else begin
          e4 = q4.pop_front();
          cmp("dout4", 64'(dout4), 64'(e4.dout));
          cmp("passes4", 64'(passes4), 64'(e4.passes));
          cmp("lat4", 64'(lat4), 64'(2 * e4.passes));
        end
      end
      cmp("excl4", 64'(busy4 & done4), 64'(0));
      pb4 = busy4; pd4 = done4;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      lat7 = 0; pb7 = 0; pd7 = 0;
    end else begin
      if (busy7) lat7 = pb7 ? lat7 + 1 : 1;
      if (done7 && !pd7) begin
        if (q7.size() == 0) begin
          miss("exp7");
        end else begin
          e7 = q7.pop_front();
          cmp("dout7", 64'(dout7), 64'(e7.dout));
          cmp("passes7", 64'(passes7), 64'(e7.passes));
          cmp("pmax7", 64'(passes7 <= 4'd4), 64'(1));
          cmp("lat7", 64'(lat7), 64'(2 * e7.passes));
        end
      end
      pb7 = busy7; pd7 = done7;
    end
  end

  // Reference: insertion sort for the result, transposition count for passes.
  function automatic void model7(input logic [55:0] d, input logic ds,
                                 output logic [55:0] s, output int p);
    int a[7], b[7], t, j;
    bit sw;
    for (int i = 0; i < 7; i++) begin
      a[i] = int'(d[i*8 +: 8]);
      b[i] = a[i];
    end
    for (int i = 1; i < 7; i++) begin
      j = i;
      while (j > 0 && (ds ? b[j-1] < b[j] : b[j-1] > b[j])) begin
        t = b[j]; b[j] = b[j-1]; b[j-1] = t; j--;
      end
    end
    for (int i = 0; i < 7; i++) s[i*8 +: 8] = 8'(b[i]);
    p = 0;
    do begin
      sw = 0;
      for (int ph = 0; ph < 2; ph++)
        for (int i = ph; i + 1 < 7; i += 2)
          if (ds ? a[i] < a[i+1] : a[i] > a[i+1]) begin
            t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1;
          end
      p++;
    end while (sw && p < 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input bit sel);
    int k = 0;
    while (!(sel ? done7 : done4) && k < 40) begin
      tick();
      k++;
    end
    if (!(sel ? done7 : done4)) miss(sel ? "timeout7" : "timeout4");
    @(negedge clk);
    #1;
  endtask

  task automatic go4(input logic [15:0] d, input logic ds);
    din4 = d; desc4 = ds; start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic sort4(input logic [15:0] d, input logic ds,
                       input logic [15:0] e, input int p);
    q4.push_back('{56'(e), p});
    go4(d, ds);
    wait_done(1'b0);
  endtask

  task automatic sort7(input logic [55:0] d, input logic ds);
    logic [55:0] s;
    int p;
    model7(d, ds, s, p);
    q7.push_back('{s, p});
    din7 = d; desc7 = ds; start7 = 1'b1;
    tick();
    start7 = 1'b0;
    wait_done(1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    cmp("rst_dout4", 64'(dout4), 64'(0));
    cmp("rst_busy4", 64'(busy4), 64'(0));
    cmp("rst_done4", 64'(done4), 64'(0));
    cmp("rst_pass4", 64'(passes4), 64'(0));
    cmp("rst_dout7", 64'(dout7), 64'(0));
    rst_n = 1'b1;
    tick();

    sort4(16'h0123, 1'b0, 16'h3210, 2);
    sort4(16'h3210, 1'b0, 16'h3210, 1);
    sort4(16'h0213, 1'b1, 16'h0123, 2);
    sort4(16'h5255, 1'b0, 16'h5552, 2);
    sort4(16'h0123, 1'b1, 16'h0123, 1);

    // START with new DIN while busy must not disturb the sort.
    q4.push_back('{56'(16'h3210), 2});
    go4(16'h0123, 1'b0);
    tick();
    din4 = 16'hFFFF; desc4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_done(1'b0);

    // Restart from FINISH: DONE drops right after the capture edge.
    q4.push_back('{56'(16'h3210), 2});
    go4(16'h2301, 1'b0);
    cmp("rs_done4", 64'(done4), 64'(0));
    cmp("rs_busy4", 64'(busy4), 64'(1));
    wait_done(1'b0);

    // Asynchronous reset in the middle of an EVEN phase.
    q4.push_back('{56'(16'h3210), 2});
    din4 = 16'h0123; desc4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    cmp("cap_dout4", 64'(dout4), 64'(16'h0123));
    #2;
    rst_n = 1'b0;
    #1;
    cmp("ar_dout4", 64'(dout4), 64'(0));
    cmp("ar_busy4", 64'(busy4), 64'(0));
    cmp("ar_done4", 64'(done4), 64'(0));
    cmp("ar_pass4", 64'(passes4), 64'(0));
    q4.delete();
    tick();
    rst_n = 1'b1;
    tick();
    sort4(16'h0123, 1'b0, 16'h3210, 2);

    for (int n = 0; n < 200; n++)
      sort7({24'($urandom), $urandom}, 1'($urandom_range(0, 1)));

    tick();
    cmp("q4_empty", 64'(q4.size()), 64'(0));
    cmp("q7_empty", 64'(q7.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sort_engine.md
# param_sort_engine

Parametrised sorting engine: accepts N unsigned W-bit elements, sorts them in ascending or descending order by odd-even transposition, and presents the sorted vector with a done flag. It is the general-purpose successor to the fixed four-digit BCD sorter. It sits between switch/button input logic, which supplies the packed operands and a start pulse, and the display multiplexor, which shows DOUT. It stops early when a full pass makes no swaps and reports how many passes it used.

## Interface
- N, default 4: element count, N ≥ 2.
- W, default 4: element width in bits.
- PW, default $clog2(N)+1: PASSES width, derived; not overridden.

- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request a sort; level-sampled each edge.
- DESC  in  1  0 = ascending, 1 = descending; sampled with START.
- DIN  in  N*W  packed operands; element i = DIN[i*W +: W].
- DOUT  out  N*W  working/sorted array, same packing.
- BUSY  out  1  high while sorting.
- DONE  out  1  high while DOUT holds a completed result.
- PASSES  out  PW  number of passes the last or current sort used.

## Operation
- States: IDLE, EVEN, ODD, FINISH.
- IDLE or FINISH, START=1:
  - Capture DIN into the array and DESC into a mode register.
  - Clear PASSES and the swap flag.
  - Go to EVEN.
- START in EVEN or ODD is ignored. DIN and DESC changes are ignored outside the capture edge.
- EVEN, one edge: compare-swap pairs (0,1), (2,3), …
  - Record whether any pair swapped.
  - Go to ODD.
- ODD, one edge: compare-swap pairs (1,2), (3,4), …
  - Increment PASSES.
  - If no swap in the EVEN or ODD phase of this pass, or PASSES reaches ceil(N/2), go to FINISH.
  - Otherwise clear the swap flag and go to EVEN.
- Compare-swap rule: unsigned compare.
  - Ascending: swap when elem[i] > elem[i+1].
  - Descending: swap when elem[i] < elem[i+1].
  - Equal elements never swap.
- Unpaired edge elements hold in each phase: the last element when N is even in ODD; the last element when N is odd in EVEN; element 0 in ODD.
- FINISH: the array holds; DONE=1 until the next START is accepted.
- DOUT is the array register at all times; it is valid only when DONE=1.
- BUSY = (state is EVEN or ODD). DONE = (state is FINISH). Both are registered state decodes, never both high.

## Timing
- Reset, asynchronous and immediate: state IDLE; array, mode, PASSES, swap flag = 0; so DOUT=0, BUSY=0, DONE=0, PASSES=0.
- Reset mid-sort aborts with no result retained.
- Capture edge t0: BUSY rises after t0; DONE falls after t0 if it was set.
- Each phase takes exactly one cycle; a pass takes two.
- Already sorted input: FINISH after edge t0+2; DONE high from then on.
- Worst case: FINISH after edge t0 + 2*ceil(N/2), which is guaranteed sorted for odd-even transposition.
- START held high in FINISH restarts immediately. DONE drops for the whole sort, and the result is overwritten at the capture edge.
- PASSES updates on each ODD edge and is final when DONE rises.

## Test plan
- N=4, W=4, ascending, elements e0..e3 = 3,2,1,0 → after the EVEN edge 2,3,0,1; after ODD 2,0,3,1; after EVEN 0,2,1,3; after ODD 0,1,2,3. PASSES=2; DONE rises 4 edges after capture.
- Ascending, 0,1,2,3 → unchanged; PASSES=1; DONE 2 edges after capture.
- DESC=1, 3,1,2,0 → 3,2,1,0; ties 5,5,2,5 ascending → 2,5,5,5 with no swaps between equals.
- START pulsed while BUSY, with new DIN → ignored; the result matches the original DIN. START held in FINISH → new sort begins, DONE low for its duration.
- RST_N asserted low mid-EVEN, asynchronous to CLK → DOUT=0, BUSY=0, DONE=0, PASSES=0 immediately. The next START sorts correctly.
- N=7, W=8: 200 random vectors, ascending and descending, against a reference model. PASSES ≤ 4; DONE latency = 2*PASSES edges.
